// File: rtl/edf_arbiter.sv
// Earliest-deadline-first interrupt arbiter: sequentially scans one gateway cell per
// cycle, presents the earliest-deadline pending source and issues a one-hot claim on ack.
module edf_arbiter #(
   parameter int unsigned NrSrc   = 4,
   parameter int unsigned DlWidth = 64,
   parameter int unsigned IdWidth = $clog2(NrSrc)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NrSrc-1:0]           ip_i,
   input  logic [NrSrc*DlWidth-1:0]   dl_i,
   input  logic                       ack_i,
   output logic                       irq_o,
   output logic [IdWidth-1:0]         irq_id_o,
   output logic [DlWidth-1:0]         irq_dl_o,
   output logic [NrSrc-1:0]           claim_o
);

   typedef enum logic {SCAN, CLAIM} state_e;

   localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrSrc - 1);

   state_e               state_q, state_d;
   logic [IdWidth-1:0]   idx_q, idx_d;
   logic                 cand_valid_q, cand_valid_d;
   logic [IdWidth-1:0]   cand_id_q, cand_id_d;
   logic [DlWidth-1:0]   cand_dl_q, cand_dl_d;
   logic                 irq_q, irq_d;
   logic [IdWidth-1:0]   irq_id_q, irq_id_d;
   logic [DlWidth-1:0]   irq_dl_q, irq_dl_d;
   logic [NrSrc-1:0]     claim_q, claim_d;

   logic [DlWidth-1:0]   dl_arr [NrSrc];
   logic [DlWidth-1:0]   cur_dl;
   logic                 hit;
   logic                 eval_valid;
   logic [IdWidth-1:0]   eval_id;
   logic [DlWidth-1:0]   eval_dl;

   always_comb begin
      for (int unsigned k = 0; k < NrSrc; k++) begin
         dl_arr[k] = dl_i[k*DlWidth +: DlWidth];
      end
   end

   assign cur_dl = dl_arr[idx_q];

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cand_valid_d = cand_valid_q;
      cand_id_d    = cand_id_q;
      cand_dl_d    = cand_dl_q;
      irq_d        = irq_q;
      irq_id_d     = irq_id_q;
      irq_dl_d     = irq_dl_q;
      claim_d      = '0;

      // Strict less-than keeps the earlier candidate on ties: lowest index wins.
      hit        = ip_i[idx_q] && (!cand_valid_q || (cur_dl < cand_dl_q));
      eval_valid = cand_valid_q | hit;
      eval_id    = hit ? idx_q  : cand_id_q;
      eval_dl    = hit ? cur_dl : cand_dl_q;

      case (state_q)
         SCAN: begin
            if (ack_i && irq_q) begin
               claim_d      = NrSrc'(1) << irq_id_q;
               irq_d        = 1'b0;
               state_d      = CLAIM;
               cand_valid_d = 1'b0;
               cand_id_d    = '0;
               cand_dl_d    = '0;
               idx_d        = '0;
            end else begin
               if (irq_q && !ip_i[irq_id_q]) begin
                  irq_d = 1'b0;
               end
               // A completed scan overrides the drop check above.
               if (idx_q == LastIdx) begin
                  irq_d = eval_valid;
                  if (eval_valid) begin
                     irq_id_d = eval_id;
                     irq_dl_d = eval_dl;
                  end
                  cand_valid_d = 1'b0;
                  cand_id_d    = '0;
                  cand_dl_d    = '0;
                  idx_d        = '0;
               end else begin
                  cand_valid_d = eval_valid;
                  cand_id_d    = eval_id;
                  cand_dl_d    = eval_dl;
                  idx_d        = idx_q + IdWidth'(1);
               end
            end
         end
         CLAIM: begin
            state_d = SCAN;
            idx_d   = '0;
         end
         default: begin
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= SCAN;
         idx_q        <= '0;
         cand_valid_q <= 1'b0;
         cand_id_q    <= '0;
         cand_dl_q    <= '0;
         irq_q        <= 1'b0;
         irq_id_q     <= '0;
         irq_dl_q     <= '0;
         claim_q      <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cand_valid_q <= cand_valid_d;
         cand_id_q    <= cand_id_d;
         cand_dl_q    <= cand_dl_d;
         irq_q        <= irq_d;
         irq_id_q     <= irq_id_d;
         irq_dl_q     <= irq_dl_d;
         claim_q      <= claim_d;
      end
   end

   assign irq_o    = irq_q;
   assign irq_id_o = irq_id_q;
   assign irq_dl_o = irq_dl_q;
   assign claim_o  = claim_q;

endmodule

// File: tb/tb_edf_arbiter.sv
// Bench for edf_arbiter: directed scenarios plus randomized traffic checked against
// a scan-snapshot argmin reference model.
module tb_edf_arbiter;

   localparam int N = 4;
   localparam int W = 64;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     ip    = '0;
   logic [N*W-1:0]   dl    = '0;
   logic             ack   = 1'b0;
   logic             irq;
   logic [1:0]       irq_id;
   logic [W-1:0]     irq_dl;
   logic [N-1:0]     claim;

   int n_total = 0;
   int n_pass  = 0;

   // reference model state
   int           m_pos;
   bit           m_in_claim;
   bit           m_irq;
   int           m_id;
   logic [W-1:0] m_dl;
   logic [N-1:0] m_claim;
   bit           m_sip [N];
   logic [W-1:0] m_sdl [N];

   edf_arbiter #(.NrSrc(N), .DlWidth(W)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .ip_i     (ip),
      .dl_i     (dl),
      .ack_i    (ack),
      .irq_o    (irq),
      .irq_id_o (irq_id),
      .irq_dl_o (irq_dl),
      .claim_o  (claim)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

   task automatic set_dl(input int k, input logic [W-1:0] v);
      dl[k*W +: W] = v;
   endtask

   task automatic model_reset();
      m_pos = 0; m_in_claim = 0; m_irq = 0; m_id = 0; m_dl = '0; m_claim = '0;
   endtask

   // One clock of the arbiter at the rules level: snapshot each source as the scan
   // passes it, then pick the earliest deadline (lowest index on ties) at the end.
   task automatic model_step();
      m_claim = '0;
      if (m_in_claim) begin
         m_in_claim = 0;
         m_pos = 0;
         return;
      end
      if (ack && m_irq) begin
         m_claim = N'(1) << m_id;
         m_irq = 0;
         m_in_claim = 1;
         m_pos = 0;
         return;
      end
      m_sip[m_pos] = ip[m_pos];
      m_sdl[m_pos] = dl[m_pos*W +: W];
      if (m_irq && !ip[m_id]) m_irq = 0;
      if (m_pos == N-1) begin
         int best;
         best = -1;
         for (int k = 0; k < N; k++)
            if (m_sip[k] && (best < 0 || m_sdl[k] < m_sdl[best])) best = k;
         if (best >= 0) begin
            m_irq = 1; m_id = best; m_dl = m_sdl[best];
         end else begin
            m_irq = 0;
         end
         m_pos = 0;
      end else begin
         m_pos++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %0h want 0", irq); else n_pass++;
      n_total++; if (irq_id !== 2'd0) $display("FAIL reset_id: got %0h want 0", irq_id); else n_pass++;
      n_total++; if (irq_dl !== '0) $display("FAIL reset_dl: got %0h want 0", irq_dl); else n_pass++;
      n_total++; if (claim !== 4'b0000) $display("FAIL reset_claim: got %b want 0000", claim); else n_pass++;
      ip = 4'b0100;
      set_dl(2, 64'd100);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      repeat (3) tick();
      n_total++; if (irq !== 1'b0) $display("FAIL single_early: got %0h want 0", irq); else n_pass++;
      tick();
      n_total++; if (irq !== 1'b1) $display("FAIL single_irq: got %0h want 1", irq); else n_pass++;
      n_total++; if (irq_id !== 2'd2) $display("FAIL single_id: got %0d want 2", irq_id); else n_pass++;
      n_total++; if (irq_dl !== 64'd100) $display("FAIL single_dl: got %0d want 100", irq_dl); else n_pass++;
   endtask

   task automatic test_tie();
      ip = 4'b1011;
      set_dl(0, 64'd50); set_dl(1, 64'd30); set_dl(3, 64'd30);
      repeat (4) tick();
      n_total++; if (irq !== 1'b1) $display("FAIL tie_irq: got %0h want 1", irq); else n_pass++;
      n_total++; if (irq_id !== 2'd1) $display("FAIL tie_id: got %0d want 1", irq_id); else n_pass++;
      n_total++; if (irq_dl !== 64'd30) $display("FAIL tie_dl: got %0d want 30", irq_dl); else n_pass++;
   endtask

   task automatic test_preempt();
      ip = 4'b0011;
      repeat (4) tick();
      n_total++; if (irq_id !== 2'd1) $display("FAIL preempt_pre_id: got %0d want 1", irq_id); else n_pass++;
      ip = 4'b1011;
      set_dl(3, 64'd10);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if ({irq, irq_id} !== 3'b101) $display("FAIL preempt_hold: got irq=%0h id=%0d want irq=1 id=1", irq, irq_id); else n_pass++;
         n_total++; if (claim !== 4'b0000) $display("FAIL preempt_noclaim: got %b want 0000", claim); else n_pass++;
      end
      tick();
      n_total++; if (irq_id !== 2'd3) $display("FAIL preempt_id: got %0d want 3", irq_id); else n_pass++;
      n_total++; if (irq_dl !== 64'd10) $display("FAIL preempt_dl: got %0d want 10", irq_dl); else n_pass++;
      n_total++; if (claim !== 4'b0000) $display("FAIL preempt_claim: got %b want 0000", claim); else n_pass++;
   endtask

   task automatic test_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_total++; if (claim !== 4'b1000) $display("FAIL ack_claim: got %b want 1000", claim); else n_pass++;
      n_total++; if (irq !== 1'b0) $display("FAIL ack_irq: got %0h want 0", irq); else n_pass++;
      ip = 4'b0011;
      tick();
      n_total++; if (claim !== 4'b0000) $display("FAIL ack_claim_once: got %b want 0000", claim); else n_pass++;
      repeat (3) tick();
      n_total++; if (irq !== 1'b0) $display("FAIL ack_rescan_early: got %0h want 0", irq); else n_pass++;
      tick();
      n_total++; if (irq !== 1'b1 || irq_id !== 2'd1) $display("FAIL ack_rescan: got irq=%0h id=%0d want irq=1 id=1", irq, irq_id); else n_pass++;
   endtask

   task automatic test_ack_boundary();
      ip = 4'b1011;
      repeat (3) tick();
      n_total++; if (irq !== 1'b1 || irq_id !== 2'd1) $display("FAIL ackb_pre: got irq=%0h id=%0d want irq=1 id=1", irq, irq_id); else n_pass++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_total++; if (claim !== 4'b0010) $display("FAIL ackb_claim: got %b want 0010", claim); else n_pass++;
      n_total++; if (irq !== 1'b0) $display("FAIL ackb_discard: got %0h want 0", irq); else n_pass++;
      ip = 4'b1001;
      repeat (4) tick();
      n_total++; if (irq !== 1'b0) $display("FAIL ackb_restart: got %0h want 0", irq); else n_pass++;
      tick();
      n_total++; if (irq !== 1'b1 || irq_id !== 2'd3 || irq_dl !== 64'd10) $display("FAIL ackb_new: got irq=%0h id=%0d dl=%0d want 1/3/10", irq, irq_id, irq_dl); else n_pass++;
   endtask

   task automatic test_drop();
      ip = 4'b0001;
      tick();
      n_total++; if (irq !== 1'b0) $display("FAIL drop_irq: got %0h want 0", irq); else n_pass++;
      n_total++; if (claim !== 4'b0000) $display("FAIL drop_claim: got %b want 0000", claim); else n_pass++;
      repeat (3) tick();
      n_total++; if (irq !== 1'b1 || irq_id !== 2'd0 || irq_dl !== 64'd50) $display("FAIL drop_next: got irq=%0h id=%0d dl=%0d want 1/0/50", irq, irq_id, irq_dl); else n_pass++;
   endtask

   task automatic test_latency_best();
      ip = 4'b0000;
      repeat (4) tick();
      n_total++; if (irq !== 1'b0 || irq_id !== 2'd0 || irq_dl !== 64'd50) $display("FAIL empty_hold: got irq=%0h id=%0d dl=%0d want 0/0/50", irq, irq_id, irq_dl); else n_pass++;
      repeat (3) tick();
      ip = 4'b1000;
      tick();
      n_total++; if (irq !== 1'b1 || irq_id !== 2'd3) $display("FAIL best_latency: got irq=%0h id=%0d want 1/3", irq, irq_id); else n_pass++;
   endtask

   task automatic test_reset_mid();
      ip = 4'b0100;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      n_total++; if ({irq, irq_id, irq_dl, claim} !== '0) $display("FAIL rstmid_scan: got irq=%0h id=%0d dl=%0d claim=%b want all 0", irq, irq_id, irq_dl, claim); else n_pass++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();
      n_total++; if (irq !== 1'b1 || irq_id !== 2'd2) $display("FAIL rstmid_rescan: got irq=%0h id=%0d want 1/2", irq, irq_id); else n_pass++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_total++; if (claim !== 4'b0100) $display("FAIL rstclaim_pre: got %b want 0100", claim); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (claim !== 4'b0000 || irq !== 1'b0) $display("FAIL rstmid_claim: got claim=%b irq=%0h want 0000/0", claim, irq); else n_pass++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_total++; if (claim !== 4'b0000) $display("FAIL rstclaim_after: got %b want 0000", claim); else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) ip = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 3) == 0) set_dl(int'($urandom_range(0, 3)), {$urandom, $urandom});
            else set_dl(int'($urandom_range(0, 3)), 64'($urandom_range(0, 7)));
         end
         ack = ($urandom_range(0, 3) == 0);
         tick();
         n_total++; if (irq !== m_irq) $display("FAIL rnd_irq c=%0d: got %0h want %0h", c, irq, m_irq); else n_pass++;
         n_total++; if (irq_id !== 2'(m_id)) $display("FAIL rnd_id c=%0d: got %0d want %0d", c, irq_id, m_id); else n_pass++;
         n_total++; if (irq_dl !== m_dl) $display("FAIL rnd_dl c=%0d: got %0h want %0h", c, irq_dl, m_dl); else n_pass++;
         n_total++; if (claim !== m_claim) $display("FAIL rnd_claim c=%0d: got %b want %b", c, claim, m_claim); else n_pass++;
      end
      ack = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_tie();
      test_preempt();
      test_ack();
      test_ack_boundary();
      test_drop();
      test_latency_best();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/edf_arbiter.md
EDF_ARBITER -- requirements
Module: edf_arbiter

Interface
REQ-001 The block SHALL have parameter NrSrc, default 4, meaning the number of gateway cells served (legal range 2..1024).
REQ-002 The block SHALL have parameter DlWidth, default 64, meaning the deadline width, equal to the gateway TsWdith.
REQ-003 The block SHALL have parameter IdWidth, default $clog2(NrSrc), meaning the source index width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port ip_i, input, NrSrc bits: pending flag per gateway cell.
REQ-007 The block SHALL have port dl_i, input, NrSrc x DlWidth bits: absolute deadline per gateway cell.
REQ-008 The block SHALL have port ack_i, input, 1 bit: the core accepts the presented interrupt.
REQ-009 The block SHALL have port irq_o, output, 1 bit: interrupt request to the core.
REQ-010 The block SHALL have port irq_id_o, output, IdWidth bits: index of the presented source.
REQ-011 The block SHALL have port irq_dl_o, output, DlWidth bits: deadline of the presented source.
REQ-012 The block SHALL have port claim_o, output, NrSrc bits: one-hot claim pulse, bit k driving claim_i of gateway cell k.

Function
REQ-013 The block SHALL implement a two-state FSM, SCAN and CLAIM, with scan index idx (IdWidth bits), best-candidate registers (valid, id, dl) and presentation registers driving irq_o, irq_id_o and irq_dl_o.
REQ-014 In SCAN, the block SHALL evaluate exactly source idx per cycle; if ip_i[idx]=1 and (cand_valid=0 or dl_i[idx] < cand_dl, unsigned, full DlWidth), the candidate SHALL become {1, idx, dl_i[idx]}.
REQ-015 Ties SHALL keep the earlier candidate, so the lowest index wins among equal deadlines.
REQ-016 On the cycle idx=NrSrc-1 is evaluated, including that source's contribution, the block SHALL load the presentation registers from the final candidate (irq_o=valid), clear the candidate, and wrap idx to 0; the outputs SHALL change the next cycle.
REQ-017 If a completed scan finds no pending source, irq_o SHALL go to 0 and irq_id_o/irq_dl_o SHALL hold their previous values.
REQ-018 A completed scan SHALL replace the presented interrupt, so an earlier-deadline arrival preempts at the next scan boundary.
REQ-019 In SCAN with irq_o=1 and ip_i[irq_id_o]=0 (and no ack_i), irq_o SHALL clear on the next cycle while scanning continues.
REQ-020 ack_i=1 while irq_o=1 SHALL, on the next cycle, drive claim_o = one-hot(irq_id_o) for exactly one cycle, set irq_o=0, enter CLAIM, and discard the partial scan (candidate cleared, idx=0).
REQ-021 ack_i SHALL take priority over a same-cycle scan completion and over a same-cycle ip_i drop of the presented source.
REQ-022 ack_i while irq_o=0 SHALL be ignored.
REQ-023 CLAIM SHALL last exactly one cycle, with no evaluation and ack_i ignored, then return to SCAN at idx=0, giving the gateway one cycle to clear ip.
REQ-024 claim_o SHALL be all-zero except in the CLAIM state.
REQ-025 Worst-case latency from ip_i rising to irq_o rising SHALL be 2*NrSrc cycles; best case SHALL be 1 cycle (source NrSrc-1 rising during its own evaluation).
REQ-026 dl_i values SHALL be sampled only when evaluated, so changes to already-evaluated sources take effect at the next scan.

Reset
REQ-027 On rst_ni=0, the block SHALL asynchronously force state=SCAN, idx=0, cand_valid=0, cand_id=0, cand_dl=0, irq_o=0, irq_id_o=0, irq_dl_o=0, claim_o=0.
REQ-028 On the first rising edge after rst_ni deasserts, the block SHALL evaluate source 0.
REQ-029 Reset mid-scan or mid-CLAIM SHALL abandon all state, with no claim pulse issued.

Verification (NrSrc=4, DlWidth=64)
REQ-030 The bench SHALL check: ip_i=4'b0100, dl_i[2]=100 from reset -> irq_o=1, irq_id_o=2, irq_dl_o=100 after the first full scan (cycle 4).
REQ-031 The bench SHALL check: ip_i=4'b1011, dl=[50,30,-,30] -> irq_id_o=1, irq_dl_o=30 (tie resolved to the lower index).
REQ-032 The bench SHALL check: presenting id 1 (dl=30), then ip_i[3] rising with dl=10 -> after the next scan boundary, irq_id_o=3, irq_dl_o=10, with no claim.
REQ-033 The bench SHALL check: ack_i pulse with irq_id_o=3 -> claim_o=4'b1000 for one cycle, irq_o=0 the same cycle, scan restarting at idx=0 two cycles after ack_i.
REQ-034 The bench SHALL check: ack_i on the same cycle as scan completion with a different winner -> the claim goes to the old irq_id_o and the new result is discarded.
REQ-035 The bench SHALL check: presented source ip drops with no ack -> irq_o=0 next cycle, no claim_o; rst_ni pulse mid-scan -> all outputs 0 immediately.
